// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Schedules the dual-port synchronous data memory between two store-buffer
//   commit slots and two load dispatch slots. Up to two requests are granted
//   each cycle; granted requests fill port A first, then port B. Load tags are
//   returned one cycle after the grant, aligned with the RAM q_a/q_b output.
//
//   Optional feature macro: DMEM_STARVE_GUARD_EN
//     defined   : starvation counter plus the one-cycle LOAD_PRI state
//     undefined : stores have strict priority; loads use leftover ports only
//
//   Ports
//     clk, rst                        clock, synchronous active-high reset
//     st_valid/addr/data 0,1          store commit requests (slot 0 older)
//     st_grant0/1                     store accepted this cycle (comb)
//     ld_valid/addr/tag 0,1           load requests (slot 0 older)
//     ld_grant0/1                     load accepted this cycle (comb)
//     mem_addr/data/wren _a,_b        memory port controls (comb)
//     resp_valid/tag _a,_b            registered load-return tags
//     drain_req, drain_done           store flush request / completion pulse
module dmem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid0,
   input  logic              st_valid1,
   input  logic [ADDR_W-1:0] st_addr0,
   input  logic [ADDR_W-1:0] st_addr1,
   input  logic [DATA_W-1:0] st_data0,
   input  logic [DATA_W-1:0] st_data1,
   output logic              st_grant0,
   output logic              st_grant1,
   input  logic              ld_valid0,
   input  logic              ld_valid1,
   input  logic [ADDR_W-1:0] ld_addr0,
   input  logic [ADDR_W-1:0] ld_addr1,
   input  logic [TAG_W-1:0]  ld_tag0,
   input  logic [TAG_W-1:0]  ld_tag1,
   output logic              ld_grant0,
   output logic              ld_grant1,
   output logic [ADDR_W-1:0] mem_addr_a,
   output logic [ADDR_W-1:0] mem_addr_b,
   output logic [DATA_W-1:0] mem_data_a,
   output logic [DATA_W-1:0] mem_data_b,
   output logic              mem_wren_a,
   output logic              mem_wren_b,
   output logic              resp_valid_a,
   output logic              resp_valid_b,
   output logic [TAG_W-1:0]  resp_tag_a,
   output logic [TAG_W-1:0]  resp_tag_b,
   input  logic              drain_req,
   output logic              drain_done
);

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("dmem_port_arbiter: STARVE_MAX must be at least 1");
   end

   typedef enum logic [1:0] {STORE_PRI, LOAD_PRI, DRAIN} state_t;

   state_t state, state_nxt;

   logic st_ok0, st_ok1, ld_ok0, ld_ok1, haz0, haz1;
   logic load_first;
   logic ld_on_a, ld_on_b;
   logic [TAG_W-1:0] tag_a, tag_b;
   logic starve_hit;

   // ---------------- starvation guard ----------------
`ifdef DMEM_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   logic [CW-1:0] starve_cnt, starve_inc;

   always_comb begin
      starve_inc = starve_cnt;
      if (ld_grant0)
         starve_inc = '0;
      else if ((ld_valid0 || ld_valid1) && starve_cnt != SMAX)
         starve_inc = starve_cnt + 1'b1;
   end

   // Compare against the updated count so the switch happens on the edge
   // that completes the STARVE_MAX-th denied cycle.
   assign starve_hit = (state == STORE_PRI) && (starve_inc == SMAX);

   always_ff @(posedge clk) begin
      if (rst)
         starve_cnt <= '0;
      else if (starve_hit && !drain_req)
         starve_cnt <= '0;
      else
         starve_cnt <= starve_inc;
   end
`else
   assign starve_hit = 1'b0;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= STORE_PRI;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         STORE_PRI: if (drain_req)       state_nxt = DRAIN;
                    else if (starve_hit) state_nxt = LOAD_PRI;
         LOAD_PRI:  state_nxt = drain_req ? DRAIN : STORE_PRI;
         DRAIN:     if (!st_valid0 && !st_valid1) state_nxt = STORE_PRI;
         default:   state_nxt = STORE_PRI;
      endcase
   end

   // ---------------- FSM: outputs (grants, ports) ----------------
   always_comb begin
      load_first = (state == LOAD_PRI);
      drain_done = !rst && (state == DRAIN) && !st_valid0 && !st_valid1;

      // Hazard checks use st_valid, not st_grant: a pending store blocks a
      // matching load even if the store itself is not issued this cycle.
      haz0   = (st_valid0 && ld_addr0 == st_addr0) || (st_valid1 && ld_addr0 == st_addr1);
      haz1   = (st_valid0 && ld_addr1 == st_addr0) || (st_valid1 && ld_addr1 == st_addr1);
      st_ok0 = st_valid0;
      st_ok1 = st_valid0 && st_valid1;
      ld_ok0 = ld_valid0 && !haz0 && (state != DRAIN);
      ld_ok1 = ld_ok0 && ld_valid1 && !haz1;

      st_grant0 = 1'b0;
      st_grant1 = 1'b0;
      ld_grant0 = 1'b0;
      ld_grant1 = 1'b0;
      if (!rst) begin
         if (load_first) begin
            ld_grant0 = ld_ok0;
            ld_grant1 = ld_ok1;
            st_grant0 = st_ok0 && !ld_ok1;
            st_grant1 = st_ok1 && !ld_ok0;
         end else begin
            st_grant0 = st_ok0;
            st_grant1 = st_ok1;
            ld_grant0 = ld_ok0 && !st_ok1;
            ld_grant1 = ld_ok1 && !st_ok0;
         end
      end

      mem_addr_a = '0; mem_data_a = '0; mem_wren_a = 1'b0;
      mem_addr_b = '0; mem_data_b = '0; mem_wren_b = 1'b0;
      ld_on_a = 1'b0; ld_on_b = 1'b0;
      tag_a = '0; tag_b = '0;

      // Port A: first granted request in priority order.
      if (load_first && ld_grant0) begin
         mem_addr_a = ld_addr0; ld_on_a = 1'b1; tag_a = ld_tag0;
      end else if (st_grant0) begin
         mem_addr_a = st_addr0; mem_data_a = st_data0; mem_wren_a = 1'b1;
      end else if (ld_grant0) begin
         mem_addr_a = ld_addr0; ld_on_a = 1'b1; tag_a = ld_tag0;
      end

      // Port B: second granted request in priority order.
      if (load_first) begin
         if (ld_grant1) begin
            mem_addr_b = ld_addr1; ld_on_b = 1'b1; tag_b = ld_tag1;
         end else if (ld_grant0 && st_grant0) begin
            mem_addr_b = st_addr0; mem_data_b = st_data0; mem_wren_b = 1'b1;
         end else if (st_grant1) begin
            mem_addr_b = st_addr1; mem_data_b = st_data1; mem_wren_b = 1'b1;
         end
      end else begin
         if (st_grant1) begin
            mem_addr_b = st_addr1; mem_data_b = st_data1; mem_wren_b = 1'b1;
         end else if (st_grant0 && ld_grant0) begin
            mem_addr_b = ld_addr0; ld_on_b = 1'b1; tag_b = ld_tag0;
         end else if (ld_grant1) begin
            mem_addr_b = ld_addr1; ld_on_b = 1'b1; tag_b = ld_tag1;
         end
      end
   end

   // ---------------- load response pipeline ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_a <= 1'b0;
         resp_valid_b <= 1'b0;
         resp_tag_a   <= '0;
         resp_tag_b   <= '0;
      end else begin
         resp_valid_a <= ld_on_a;
         resp_valid_b <= ld_on_b;
         resp_tag_a   <= tag_a;
         resp_tag_b   <= tag_b;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Directed-vector bench for dmem_port_arbiter. Inputs change 1 time unit
//   after the rising edge; outputs are compared on the falling edge.
//   Expectations for the starvation sequence follow DMEM_STARVE_GUARD_EN.
module tb_dmem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TW = 5;

   logic          clk, rst;
   logic          st_valid0, st_valid1, ld_valid0, ld_valid1, drain_req;
   logic [AW-1:0] st_addr0, st_addr1, ld_addr0, ld_addr1;
   logic [DW-1:0] st_data0, st_data1;
   logic [TW-1:0] ld_tag0, ld_tag1;
   logic          st_grant0, st_grant1, ld_grant0, ld_grant1;
   logic [AW-1:0] mem_addr_a, mem_addr_b;
   logic [DW-1:0] mem_data_a, mem_data_b;
   logic          mem_wren_a, mem_wren_b;
   logic          resp_valid_a, resp_valid_b;
   logic [TW-1:0] resp_tag_a, resp_tag_b;
   logic          drain_done;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

`ifdef DMEM_STARVE_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif

   dmem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst(rst),
      .st_valid0(st_valid0), .st_valid1(st_valid1),
      .st_addr0(st_addr0), .st_addr1(st_addr1),
      .st_data0(st_data0), .st_data1(st_data1),
      .st_grant0(st_grant0), .st_grant1(st_grant1),
      .ld_valid0(ld_valid0), .ld_valid1(ld_valid1),
      .ld_addr0(ld_addr0), .ld_addr1(ld_addr1),
      .ld_tag0(ld_tag0), .ld_tag1(ld_tag1),
      .ld_grant0(ld_grant0), .ld_grant1(ld_grant1),
      .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
      .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
      .mem_wren_a(mem_wren_a), .mem_wren_b(mem_wren_b),
      .resp_valid_a(resp_valid_a), .resp_valid_b(resp_valid_b),
      .resp_tag_a(resp_tag_a), .resp_tag_b(resp_tag_b),
      .drain_req(drain_req), .drain_done(drain_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      st_valid0 = 0; st_valid1 = 0; ld_valid0 = 0; ld_valid1 = 0; drain_req = 0;
      st_addr0 = '0; st_addr1 = '0; st_data0 = '0; st_data1 = '0;
      ld_addr0 = '0; ld_addr1 = '0; ld_tag0 = '0; ld_tag1 = '0;
   endtask

   task automatic set_st(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      st_valid0 = v0; st_addr0 = a0; st_data0 = d0;
      st_valid1 = v1; st_addr1 = a1; st_data1 = d1;
   endtask

   task automatic set_ld(input logic v0, input logic [AW-1:0] a0, input logic [TW-1:0] t0,
                         input logic v1, input logic [AW-1:0] a1, input logic [TW-1:0] t1);
      ld_valid0 = v0; ld_addr0 = a0; ld_tag0 = t0;
      ld_valid1 = v1; ld_addr1 = a1; ld_tag1 = t1;
   endtask

   // Wait to the compare point of the current cycle.
   task automatic sample();
      @(negedge clk);
   endtask

   // Advance to the next cycle's drive point.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr_in();
      rst = 1'b1;
      // --- reset with every request asserted ---
      set_st(1, 32'h100, 32'h1, 1, 32'h104, 32'h2);
      set_ld(1, 32'h200, 5'd1, 1, 32'h204, 5'd2);
      next(); next();
      sample();
      check("rst_st_grant", {st_grant0, st_grant1}, 2'b00);
      check("rst_ld_grant", {ld_grant0, ld_grant1}, 2'b00);
      check("rst_wren", {mem_wren_a, mem_wren_b}, 2'b00);
      check("rst_resp_valid", {resp_valid_a, resp_valid_b}, 2'b00);
      check("rst_resp_tag", {resp_tag_a, resp_tag_b}, 10'd0);
      check("rst_drain_done", drain_done, 1'b0);

      // --- mixed traffic: store on A, load on B ---
      next(); rst = 1'b0; clr_in();
      set_st(1, 32'h10, 32'hAA, 0, 32'h0, 32'h0);
      set_ld(1, 32'h20, 5'd7, 0, 32'h0, 5'd0);
      sample();
      check("mix_grants", {st_grant0, st_grant1, ld_grant0, ld_grant1}, 4'b1010);
      check("mix_port_a", {mem_wren_a, mem_addr_a, mem_data_a}, {1'b1, 32'h10, 32'hAA});
      check("mix_port_b", {mem_wren_b, mem_addr_b, mem_data_b}, {1'b0, 32'h20, 32'h0});
      next(); clr_in();
      sample();
      check("mix_resp_b", {resp_valid_a, resp_valid_b, resp_tag_b}, {1'b0, 1'b1, 5'd7});
      check("idle_ports", {mem_wren_a, mem_addr_a, mem_data_a, mem_wren_b, mem_addr_b}, 98'd0);

      // --- address hazard, younger load behind blocked ld0 ---
      next(); clr_in();
      set_st(1, 32'h40, 32'h5, 0, 32'h0, 32'h0);
      set_ld(1, 32'h40, 5'd3, 1, 32'h50, 5'd4);
      sample();
      check("haz_grants", {st_grant0, ld_grant0, ld_grant1}, 3'b100);
      check("haz_port_b_idle", {mem_wren_b, mem_addr_b}, 33'd0);
      next(); clr_in();
      set_ld(1, 32'h40, 5'd3, 0, 32'h0, 5'd0);
      sample();
      check("haz_clear_grant", {ld_grant0, mem_wren_a, mem_addr_a}, {1'b1, 1'b0, 32'h40});
      next(); clr_in();
      sample();
      check("haz_resp_a", {resp_valid_a, resp_tag_a, resp_valid_b}, {1'b1, 5'd3, 1'b0});

      // --- full load: two stores win both ports ---
      next(); clr_in();
      set_st(1, 32'h100, 32'h11, 1, 32'h104, 32'h22);
      set_ld(1, 32'h200, 5'd1, 1, 32'h204, 5'd2);
      sample();
      check("full_grants", {st_grant0, st_grant1, ld_grant0, ld_grant1}, 4'b1100);
      check("full_port_b", {mem_wren_b, mem_addr_b, mem_data_b}, {1'b1, 32'h104, 32'h22});

      // --- two loads fill both ports ---
      next(); clr_in();
      set_ld(1, 32'h60, 5'd1, 1, 32'h64, 5'd2);
      sample();
      check("ld2_grants", {ld_grant0, ld_grant1}, 2'b11);
      check("ld2_ports", {mem_addr_a, mem_addr_b, mem_wren_a, mem_wren_b}, {32'h60, 32'h64, 2'b00});

      // --- starvation: both stores every cycle, ld0 pending ---
      next(); clr_in();
      set_st(1, 32'h100, 32'h31, 1, 32'h104, 32'h32);
      set_ld(1, 32'h200, 5'd9, 0, 32'h0, 5'd0);
      sample();
      check("ld2_resp", {resp_valid_a, resp_tag_a, resp_valid_b, resp_tag_b}, {1'b1, 5'd1, 1'b1, 5'd2});
      check("starve_c1", ld_grant0, 1'b0);
      for (int i = 2; i <= 4; i++) begin
         next();
         sample();
         check($sformatf("starve_c%0d", i), {ld_grant0, st_grant0, st_grant1}, 3'b011);
      end
      next();
      sample();
      if (GUARD) begin
         check("starve_c5_grants", {ld_grant0, st_grant0, st_grant1}, 3'b110);
         check("starve_c5_port_a", {mem_wren_a, mem_addr_a}, {1'b0, 32'h200});
         check("starve_c5_port_b", {mem_wren_b, mem_addr_b, mem_data_b}, {1'b1, 32'h100, 32'h31});
      end else begin
         check("starve_c5_grants", {ld_grant0, st_grant0, st_grant1}, 3'b011);
         check("starve_c5_port_a", {mem_wren_a, mem_addr_a}, {1'b1, 32'h100});
      end
      next();
      sample();
      check("starve_c6_grants", {ld_grant0, st_grant0, st_grant1}, 3'b011);
      check("starve_c6_resp", {resp_valid_a, resp_tag_a}, GUARD ? {1'b1, 5'd9} : 6'd0);

      // lone load clears the starvation count
      next(); clr_in();
      set_ld(1, 32'h80, 5'd5, 0, 32'h0, 5'd0);
      sample();
      check("clear_grant", ld_grant0, 1'b1);

      // --- drain: 3 stores queued, load waits until stores empty ---
      next(); clr_in();
      drain_req = 1'b1;
      set_st(1, 32'h10, 32'h1, 1, 32'h14, 32'h2);
      set_ld(1, 32'h300, 5'd4, 0, 32'h0, 5'd0);
      sample();
      check("drain_d0", {st_grant0, st_grant1, ld_grant0, drain_done}, 4'b1100);
      next();
      drain_req = 1'b0;
      set_st(1, 32'h18, 32'h3, 0, 32'h0, 32'h0);
      sample();
      check("drain_d1", {st_grant0, ld_grant0, drain_done, mem_wren_b}, 4'b1000);
      check("drain_d1_port_a", {mem_addr_a, mem_data_a}, {32'h18, 32'h3});
      next();
      set_st(0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      sample();
      check("drain_d2", {ld_grant0, drain_done}, 2'b01);
      next();
      sample();
      check("drain_d3", {ld_grant0, drain_done, mem_addr_a}, {1'b1, 1'b0, 32'h300});

      // --- reset mid-operation drops in-flight response ---
      next(); clr_in();
      set_ld(1, 32'h90, 5'd6, 0, 32'h0, 5'd0);
      sample();
      check("mrst_r0", {ld_grant0, resp_valid_a, resp_tag_a}, {1'b1, 1'b1, 5'd4});
      next();
      rst = 1'b1;
      sample();
      check("mrst_r1", {ld_grant0, mem_wren_a, resp_valid_a, resp_tag_a}, {1'b0, 1'b0, 1'b1, 5'd6});
      next();
      rst = 1'b0; clr_in();
      sample();
      check("mrst_r2", {resp_valid_a, resp_valid_b}, 2'b00);

      // --- two stores to one address: st0 on A, st1 on B ---
      next(); clr_in();
      set_st(1, 32'h44, 32'hD0, 1, 32'h44, 32'hD1);
      sample();
      check("same_addr", {mem_wren_a, mem_addr_a, mem_data_a, mem_wren_b, mem_addr_b, mem_data_b},
            {1'b1, 32'h44, 32'hD0, 1'b1, 32'h44, 32'hD1});

      next(); clr_in();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
